freq_sweep_ctrl: RTL and testbench

Sequencer for the ring-oscillator / frequency-selector datapath. It holds a small programmable table of 11-bit frequency-select codes, for example 0x132 (50 MHz), 0x164 (100 MHz) and 0x1C8 (200 MHz). For each entry it enables the oscillator, drives the code onto the selector's switch bus, pulses `init`, waits for the selector to report lock, then dwells before stepping to the next entry. It replaces hand-driven switch/enable/init sequencing at the top level.

---
 rtl/fsc_pkg.sv | 32 +++
 rtl/fsc_timer.sv | 28 ++
 rtl/freq_sweep_ctrl.sv | 168 ++++++++++++++++
 tb/tb_freq_sweep_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsc_pkg.sv
// fsc_pkg: shared types and defaults for the frequency sweep sequencer.
// Optional lock-timeout feature is enabled with FSC_TIMEOUT_EN.
package fsc_pkg;

  localparam int FSC_SW_W        = 11;
  localparam int FSC_SETTLE_CYC  = 16;
  localparam int FSC_DWELL_CYC   = 1000;
  localparam int FSC_TIMEOUT_CYC = 4096;

  localparam logic [10:0] FSC_CODE_50M  = 11'h132;
  localparam logic [10:0] FSC_CODE_100M = 11'h164;
  localparam logic [10:0] FSC_CODE_200M = 11'h1C8;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD      = 4'd1,
    S_INIT      = 4'd2,
    S_SETTLE    = 4'd3,
    S_WAIT_LOCK = 4'd4,
    S_DWELL     = 4'd5,
    S_NEXT      = 4'd6,
    S_DONE      = 4'd7,
    S_ERR       = 4'd8
  } fsc_state_e;

  function automatic int fsc_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/fsc_timer.sv
// fsc_timer: loadable down-counter with zero flag.
// Shared by settle, dwell and lock-timeout intervals.
module fsc_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // reload on request, otherwise count down and hold at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/freq_sweep_ctrl.sv
// freq_sweep_ctrl: steps a ring-oscillator selector through a code table.
// Define FSC_TIMEOUT_EN to add the lock timeout and ERR state.
module freq_sweep_ctrl
  import fsc_pkg::*;
#(
  parameter int SW_W        = FSC_SW_W,
  parameter int N_STEPS     = 4,
  parameter int SETTLE_CYC  = FSC_SETTLE_CYC,
  parameter int DWELL_CYC   = FSC_DWELL_CYC,
  parameter int TIMEOUT_CYC = FSC_TIMEOUT_CYC
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       loop,
  input  logic                       wr_en,
  input  logic [$clog2(N_STEPS)-1:0] wr_addr,
  input  logic [SW_W-1:0]            wr_data,
  input  logic                       lock,
  output logic                       en,
  output logic                       init,
  output logic [SW_W-1:0]            sw,
  output logic [$clog2(N_STEPS)-1:0] step,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int AW = $clog2(N_STEPS);
  localparam int CW =
    $clog2(fsc_max3(SETTLE_CYC, DWELL_CYC, TIMEOUT_CYC) + 1);

  fsc_state_e      state_q, state_d;
  logic [AW-1:0]   step_q, step_d, nxt_idx;
  logic [SW_W-1:0] tbl_q [N_STEPS];
  logic [SW_W-1:0] sw_q;
  logic            en_q, init_q, busy_q, done_q;
  logic            last;
  logic            tmr_load, tmr_zero;
  logic [CW-1:0]   tmr_val;
  logic            run_st;

  fsc_timer #(.W(CW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (tmr_load),
    .val_i  (tmr_val),
    .zero_o (tmr_zero)
  );

  // code table, writable at any time
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_STEPS; i++) tbl_q[i] <= '0;
    end else if (wr_en) begin
      tbl_q[wr_addr] <= wr_data;
    end
  end

  // next-state, step and timer reload selection
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    nxt_idx  = step_q + AW'(1);
    last     = (step_q == AW'(N_STEPS - 1)) || (tbl_q[nxt_idx] == '0);
    if (abort) begin
      state_d = S_IDLE;
      step_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start) begin
          step_d  = '0;
          state_d = (tbl_q[0] == '0) ? S_DONE : S_LOAD;
        end
        S_LOAD:   state_d = S_INIT;
        S_INIT:   state_d = S_SETTLE;
        S_SETTLE: if (tmr_zero) state_d = S_WAIT_LOCK;
        S_WAIT_LOCK: begin
          if (lock) state_d = S_DWELL;
`ifdef FSC_TIMEOUT_EN
          else if (tmr_zero) state_d = S_ERR;
`endif
        end
        S_DWELL:  if (tmr_zero) state_d = S_NEXT;
        S_NEXT: begin
          if (!last) begin
            state_d = S_LOAD;
            step_d  = nxt_idx;
          end else if (loop) begin
            state_d = S_LOAD;
            step_d  = '0;
          end else begin
            state_d = S_DONE;
          end
        end
        S_DONE:   state_d = S_IDLE;
`ifdef FSC_TIMEOUT_EN
        S_ERR: if (start) begin
          state_d = S_LOAD;
          step_d  = '0;
        end
`endif
        default:  state_d = S_IDLE;
      endcase
    end
    tmr_load = (state_d != state_q);
    unique case (state_d)
      S_SETTLE:    tmr_val = CW'(SETTLE_CYC - 1);
      S_DWELL:     tmr_val = CW'(DWELL_CYC - 1);
      S_WAIT_LOCK: tmr_val = CW'(TIMEOUT_CYC - 1);
      default:     tmr_val = '0;
    endcase
  end

  // state and step registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  assign run_st = state_q inside
    {S_LOAD, S_INIT, S_SETTLE, S_WAIT_LOCK, S_DWELL, S_NEXT};

  // registered Moore outputs; abort clears them on the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q   <= 1'b0;
      busy_q <= 1'b0;
      init_q <= 1'b0;
      done_q <= 1'b0;
      sw_q   <= '0;
    end else begin
      en_q   <= !abort && run_st;
      busy_q <= !abort && run_st;
      init_q <= !abort && (state_q == S_INIT);
      done_q <= !abort && (state_q == S_DONE);
      if (!abort && state_q == S_LOAD) sw_q <= tbl_q[step_q];
    end
  end

`ifdef FSC_TIMEOUT_EN
  logic err_q;

  // sticky timeout flag, cleared by leaving ERR
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= !abort && !start && (state_q == S_ERR);
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign en   = en_q;
  assign init = init_q;
  assign sw   = sw_q;
  assign step = step_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// tb_freq_sweep_ctrl: scoreboard bench for freq_sweep_ctrl.
// Timeout scenario runs only when FSC_TIMEOUT_EN is defined.
module tb_freq_sweep_ctrl;

  localparam int S = 4;
  localparam int D = 8;
  localparam int T = 32;

  logic        clk = 1'b0;
  logic        rst, start, abort, loop, wr_en, lock;
  logic [1:0]  wr_addr;
  logic [10:0] wr_data;
  logic        en, init, busy, done, err;
  logic [10:0] sw;
  logic [1:0]  step;

  freq_sweep_ctrl #(
    .SW_W(11), .N_STEPS(4), .SETTLE_CYC(S),
    .DWELL_CYC(D), .TIMEOUT_CYC(T)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .loop(loop), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .lock(lock), .en(en), .init(init),
    .sw(sw), .step(step), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int code;
    int stp;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0, n_bad = 0;
  int  cyc = 0, start_edge = 0, last_init = -1;
  int  n_init = 0, n_done = 0;
  bit  start_pending = 0, lock_lo = 0, lock_rand = 0;
  bit  lock_hist [0:65535];
  int  mtab [4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cyc < 65536) lock_hist[cyc] = lock;
  end

  initial begin
    lock = 1'b1;
    forever begin
      @(negedge clk);
      if (lock_lo)        lock = 1'b0;
      else if (lock_rand) lock = ($urandom_range(0, 3) == 0);
      else                lock = 1'b1;
    end
  end

  function automatic int lock_edge(input int from, input int to);
    for (int e = from + 1 + S; e <= to && e < 65536; e++)
      if (lock_hist[e]) return e;
    return -1;
  endfunction

  // reference: walk the table by the sweep rules from index i
  task automatic model_from(input int i0, input bit lp, input int max_ld);
    int i, n;
    ev_t ev;
    i = i0;
    n = 0;
    if (i0 == 0 && mtab[0] == 0) begin
      ev = '{1'b1, 0, 0};
      exp_q.push_back(ev);
      return;
    end
    forever begin
      ev = '{1'b0, mtab[i], i};
      exp_q.push_back(ev);
      n++;
      if (n == max_ld) return;
      if (i == 3 || mtab[i + 1] == 0) begin
        if (lp) i = 0;
        else begin
          ev = '{1'b1, 0, 0};
          exp_q.push_back(ev);
          return;
        end
      end else begin
        i++;
      end
    end
  endtask

  // monitor: pop and compare on every init or done pulse
  always @(negedge clk) begin
    ev_t ev;
    if (rst === 1'b1 && (init === 1'b1 || done === 1'b1)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: got init=%0b done=%0b expected none",
                 init, done);
      end else begin
        ev = exp_q.pop_front();
        if (init === 1'b1) begin
          chk("init_kind", ev.is_done, 0);
          chk("init_sw", sw, ev.code);
          chk("init_step", step, ev.stp);
          chk("init_en", en, 1);
          chk("init_busy", busy, 1);
          if (start_pending)
            chk("start_to_init", cyc, start_edge + 2);
          else if (last_init >= 0)
            chk("lock_to_init", cyc, lock_edge(last_init, cyc) + D + 3);
          start_pending = 0;
          last_init = cyc;
          n_init++;
        end else begin
          chk("done_kind", ev.is_done, 1);
          chk("done_en", en, 0);
          chk("done_busy", busy, 0);
          if (start_pending)
            chk("start_to_done", cyc, start_edge + 1);
          else if (last_init >= 0)
            chk("lock_to_done", cyc, lock_edge(last_init, cyc) + D + 2);
          start_pending = 0;
          last_init = -1;
          n_done++;
        end
      end
    end
  end

  task automatic tb_write(input int a, input int d);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = 2'(a);
    wr_data = 11'(d);
    mtab[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic issue_start();
    @(negedge clk);
    start = 1'b1;
    start_edge = cyc + 1;
    start_pending = 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic abort_pulse();
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    exp_q.delete();
    last_init = -1;
    start_pending = 0;
  endtask

  task automatic wait_q(input int n, input int budget, input string nm);
    int k = 0;
    while (exp_q.size() > n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() > n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got %0d pending events expected <= %0d",
               nm, exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  initial begin
    int t0, cnt, saved;
    rst = 1'b0; start = 0; abort = 0; loop = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    for (int i = 0; i < 4; i++) mtab[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_en", en, 0);
    chk("rst_init", init, 0);
    chk("rst_sw", sw, 0);
    chk("rst_step", step, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b1;

    // basic sweep, with an ignored start mid-sweep
    tb_write(0, 'h132); tb_write(1, 'h164);
    tb_write(2, 'h1C8); tb_write(3, 0);
    n_init = 0; n_done = 0;
    model_from(0, 0, 99);
    issue_start();
    wait_q(2, 200, "basic_step1");
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_q(0, 300, "basic_end");
    repeat (3) @(negedge clk);
    chk("basic_inits", n_init, 3);
    chk("basic_dones", n_done, 1);
    chk("basic_en_after", en, 0);
    chk("basic_sw_kept", sw, 'h1C8);

    // lock held low on entry 1
    model_from(0, 0, 99);
    issue_start();
    wait_q(2, 200, "lockwait_step1");
    lock_lo = 1;
    repeat (1 + S + 20) @(negedge clk);
    chk("lockwait_sw", sw, 'h164);
    chk("lockwait_step", step, 1);
    lock_lo = 0;
    wait_q(0, 300, "lockwait_end");
    repeat (3) @(negedge clk);

    // loop, with a write to the active entry
    loop = 1'b1;
    model_from(0, 1, 1);
    issue_start();
    wait_q(0, 200, "loop_first");
    tb_write(0, 'h1C8);
    model_from(1, 1, 3);
    cnt = 0;
    for (int k = 0; k < 400 && exp_q.size() > 0; k++) begin
      @(negedge clk);
      if (busy !== 1'b1) cnt++;
    end
    wait_q(0, 1, "loop_end");
    chk("loop_busy_low", cnt, 0);
    repeat (2) @(negedge clk);
    saved = n_done;
    abort_pulse();
    chk("loopab_en", en, 0);
    chk("loopab_busy", busy, 0);
    chk("loopab_step", step, 0);
    chk("loopab_sw", sw, 'h1C8);
    loop = 1'b0;
    chk("loop_no_done", n_done, saved);
    tb_write(0, 'h132);

    // abort in dwell of entry 1
    model_from(0, 0, 2);
    issue_start();
    wait_q(0, 200, "abort_step1");
    t0 = last_init + S + 3;
    for (int k = 0; k < 50 && cyc < t0; k++) @(negedge clk);
    saved = n_done;
    abort_pulse();
    chk("abort_en", en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_step", step, 0);
    chk("abort_init", init, 0);
    chk("abort_sw", sw, 'h164);
    repeat (20) @(negedge clk);
    chk("abort_no_done", n_done, saved);

    // asynchronous reset during settle
    model_from(0, 0, 1);
    issue_start();
    wait_q(0, 200, "rst_step0");
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_en", en, 0);
    chk("arst_sw", sw, 0);
    chk("arst_busy", busy, 0);
    chk("arst_init", init, 0);
    exp_q.delete();
    last_init = -1;
    start_pending = 0;
    for (int i = 0; i < 4; i++) mtab[i] = 0;
    @(negedge clk);
    rst = 1'b1;

    // empty table
    model_from(0, 0, 99);
    issue_start();
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (en !== 1'b0) cnt++;
      @(negedge clk);
    end
    wait_q(0, 1, "empty_done");
    chk("empty_en_hi", cnt, 0);

    // randomized tables and lock behaviour
    lock_rand = 1;
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 4; i++)
        tb_write(i, ($urandom_range(0, 3) == 0) ? 0
                    : int'($urandom_range(1, 2047)));
      model_from(0, 0, 99);
      issue_start();
      wait_q(0, 800, "rand_sweep");
      repeat (2) @(negedge clk);
    end
    lock_rand = 0;

`ifdef FSC_TIMEOUT_EN
    tb_write(0, 'h132); tb_write(1, 'h164);
    lock_lo = 1;
    model_from(0, 0, 1);
    issue_start();
    t0 = start_edge;
    cnt = -1;
    for (int k = 0; k < 200 && cnt < 0; k++) begin
      @(negedge clk);
      if (err === 1'b1) cnt = cyc;
    end
    chk("tmo_err_time", cnt, t0 + 3 + S + T);
    chk("tmo_en", en, 0);
    chk("tmo_busy", busy, 0);
    model_from(0, 0, 1);
    issue_start();
    chk("tmo_err_clr", err, 0);
    wait_q(0, 50, "tmo_restart");
    abort_pulse();
    lock_lo = 0;
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
